// File: rtl/adder_i4_o3_seq.sv
// Registered exact 2-bit + 2-bit unsigned adder with a valid-qualified input stage.
// Optional sample/carry statistics counters are enabled by defining ADDER_I4_O3_SEQ_STATS_EN.
module adder_i4_o3_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       pi0,
  input  logic       pi1,
  input  logic       pi2,
  input  logic       pi3,
  output logic       po0,
  output logic       po1,
  output logic       po2,
  output logic       out_valid,
  output logic [7:0] sample_cnt,
  output logic [7:0] carry_cnt
);

  localparam int unsigned OpW  = 2;
  localparam int unsigned SumW = 3;
  localparam int unsigned CntW = 8;

  logic [OpW-1:0]  op_a_c;
  logic [OpW-1:0]  op_b_c;
  logic [SumW-1:0] sum_c;
  logic [SumW-1:0] sum_d, sum_q;
  logic            out_valid_d, out_valid_q;

  // Zero-extend both operands so the carry lands in the top sum bit.
  assign op_a_c = {pi1, pi0};
  assign op_b_c = {pi3, pi2};
  assign sum_c  = SumW'(op_a_c) + SumW'(op_b_c);

  always_comb begin
    sum_d       = sum_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = sum_c;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign po0       = sum_q[0];
  assign po1       = sum_q[1];
  assign po2       = sum_q[2];
  assign out_valid = out_valid_q;

`ifdef ADDER_I4_O3_SEQ_STATS_EN
  logic [CntW-1:0] sample_cnt_d, sample_cnt_q;
  logic [CntW-1:0] carry_cnt_d, carry_cnt_q;

  // Saturating counters: hold at all-ones rather than wrap.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    carry_cnt_d  = carry_cnt_q;
    if (in_valid) begin
      if (sample_cnt_q != '1) begin
        sample_cnt_d = sample_cnt_q + CntW'(1);
      end
      if (sum_c[SumW-1] && (carry_cnt_q != '1)) begin
        carry_cnt_d = carry_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      carry_cnt_q  <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      carry_cnt_q  <= carry_cnt_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign carry_cnt  = carry_cnt_q;
`else
  assign sample_cnt = CntW'(0);
  assign carry_cnt  = CntW'(0);
`endif

endmodule

// File: tb/tb_adder_i4_o3_seq.sv
// Self-checking bench for adder_i4_o3_seq: arithmetic reference model plus directed literal vectors.
// Expected counter values follow ADDER_I4_O3_SEQ_STATS_EN.
module tb_adder_i4_o3_seq;

`ifdef ADDER_I4_O3_SEQ_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       pi0, pi1, pi2, pi3;
  logic       po0, po1, po2;
  logic       out_valid;
  logic [7:0] sample_cnt;
  logic [7:0] carry_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model state
  int exp_po      = 0;
  int exp_valid   = 0;
  int exp_samples = 0;
  int exp_carries = 0;

  adder_i4_o3_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pi0       (pi0),
    .pi1       (pi1),
    .pi2       (pi2),
    .pi3       (pi3),
    .po0       (po0),
    .po1       (po1),
    .po2       (po2),
    .out_valid (out_valid),
    .sample_cnt(sample_cnt),
    .carry_cnt (carry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int po_val();
    return int'({po2, po1, po0});
  endfunction

  // Model: sum is plain integer A+B, counters are integer counts clipped at 255.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_po      <= 0;
      exp_valid   <= 0;
      exp_samples <= 0;
      exp_carries <= 0;
    end else if (in_valid) begin
      exp_po      <= (2 * int'(pi1) + int'(pi0)) + (2 * int'(pi3) + int'(pi2));
      exp_valid   <= 1;
      exp_samples <= (exp_samples < 255) ? exp_samples + 1 : 255;
      if ((2 * int'(pi1) + int'(pi0)) + (2 * int'(pi3) + int'(pi2)) >= 4)
        exp_carries <= (exp_carries < 255) ? exp_carries + 1 : 255;
    end else begin
      exp_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_po", po_val(), exp_po);
      check("model_out_valid", int'(out_valid), exp_valid);
      check("model_sample_cnt", int'(sample_cnt), Stats ? exp_samples : 0);
      check("model_carry_cnt", int'(carry_cnt), Stats ? exp_carries : 0);
    end
  end

  task automatic set_in(input bit v, input logic [3:0] code);
    in_valid = v;
    {pi3, pi2, pi1, pi0} = code;
  endtask

  // Apply one valid sample and check the literal result one cycle later.
  task automatic vec(input logic [3:0] code, input int exp);
    @(negedge clk);
    set_in(1'b1, code);
    @(negedge clk);
    check($sformatf("dir_%4b_po", code), po_val(), exp);
    check($sformatf("dir_%4b_ov", code), int'(out_valid), 1);
    set_in(1'b0, 4'b0000);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b1, 4'b1111);
    repeat (2) @(posedge clk);
    #1;
    check("rst_po", po_val(), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sample_cnt", int'(sample_cnt), 0);
    check("rst_carry_cnt", int'(carry_cnt), 0);
    cmp_en = 1'b1;

    // Release with a valid sample already present: first edge must produce a result.
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 4'b1000);
    @(negedge clk);
    check("first_after_rst_po", po_val(), 2);
    check("first_after_rst_ov", int'(out_valid), 1);
    set_in(1'b0, 4'b0000);

    vec(4'b1000, 2);
    vec(4'b0011, 3);
    vec(4'b1001, 3);
    vec(4'b0110, 3);
    vec(4'b0000, 0);
    vec(4'b1111, 6);
    vec(4'b1110, 5);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("exh_%0d_po", i - 1), po_val(), ((i - 1) % 4) + ((i - 1) / 4));
        check($sformatf("exh_%0d_ov", i - 1), int'(out_valid), 1);
      end
      if (i < 16) set_in(1'b1, 4'(i));
      else        set_in(1'b0, 4'b0000);
    end

    // Hold behaviour.
    vec(4'b0111, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d_po", i), po_val(), 4);
      check($sformatf("hold_%0d_ov", i), int'(out_valid), 0);
    end

    // Mid-run asynchronous reset between edges.
    @(negedge clk);
    set_in(1'b1, 4'b1101);
    @(posedge clk);
    #1;
    check("midrst_pre_po", po_val(), 4);
    set_in(1'b0, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_po", po_val(), 0);
    check("midrst_ov", int'(out_valid), 0);
    check("midrst_sample_cnt", int'(sample_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter saturation.
    @(negedge clk);
    set_in(1'b1, 4'b1111);
    repeat (300) @(negedge clk);
    check("sat_sample_cnt", int'(sample_cnt), Stats ? 255 : 0);
    check("sat_carry_cnt", int'(carry_cnt), Stats ? 255 : 0);
    set_in(1'b1, 4'b0000);
    @(negedge clk);
    set_in(1'b0, 4'b0000);
    check("sat_post_po", po_val(), 0);
    check("sat_post_sample_cnt", int'(sample_cnt), Stats ? 255 : 0);
    check("sat_post_carry_cnt", int'(carry_cnt), Stats ? 255 : 0);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
